// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-atomic round-robin arbiter for a shared AXI-Stream port
module axis_packet_arbiter #(
    parameter  int NUM_SOURCES = 4,
    parameter  int TDATA_WIDTH = 512,
    parameter  int TID_WIDTH   = 2,
    parameter  int TDEST_WIDTH = 4,
    localparam int GW          = $clog2(NUM_SOURCES)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_SOURCES-1:0]                   s_tvalid,
    output logic [NUM_SOURCES-1:0]                   s_tready,
    input  logic [NUM_SOURCES-1:0][TDATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_SOURCES-1:0]                   s_tlast,
    input  logic [NUM_SOURCES-1:0][TID_WIDTH-1:0]    s_tid,
    input  logic [NUM_SOURCES-1:0][TDEST_WIDTH-1:0]  s_tdest,
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic [TDATA_WIDTH-1:0]                   m_tdata,
    output logic                                     m_tlast,
    output logic [TID_WIDTH-1:0]                     m_tid,
    output logic [TDEST_WIDTH-1:0]                   m_tdest,
    output logic [GW-1:0]                            grant_id,
    output logic                                     busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [GW:0]   NS       = (GW+1)'(NUM_SOURCES);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_SOURCES - 1);

    state_t                 state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          pick;
    logic                   found;
    logic [GW:0]            cand;
    logic                   out_free;
    logic                   accept;
    logic                   m_tvalid_q;
    logic [TDATA_WIDTH-1:0] m_tdata_q;
    logic                   m_tlast_q;
    logic [TID_WIDTH-1:0]   m_tid_q;
    logic [TDEST_WIDTH-1:0] m_tdest_q;

    // Candidate index is one bit wider so rr_ptr+i can be folded back below NUM_SOURCES.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            cand = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (cand >= NS) begin
                cand = cand - NS;
            end
            if (!found && s_tvalid[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
    end

    assign out_free = !m_tvalid_q || m_tready;
    assign accept   = (state_q == LOCKED) && s_tvalid[grant_q] && out_free;

    always_comb begin
        s_tready = '0;
        if (state_q == LOCKED) begin
            s_tready[grant_q] = out_free;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && s_tlast[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            if (accept) begin
                m_tvalid_q <= 1'b1;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    // Payload needs no reset; it is only meaningful while m_tvalid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_tdata_q <= s_tdata[grant_q];
            m_tlast_q <= s_tlast[grant_q];
            m_tid_q   <= s_tid[grant_q];
            m_tdest_q <= s_tdest[grant_q];
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign m_tid    = m_tid_q;
    assign m_tdest  = m_tdest_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == LOCKED);

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-atomic round-robin arbiter that lets NUM_SOURCES AXI-Stream requesters share one NoC endpoint injection port (axis_in_* of a torus/mesh tile). A grant is held from a packet's first beat to its tlast, so packets from different sources are never interleaved. The arbiter drives the shared port through a single output register. It runs entirely in the user clock domain, upstream of the serializer shim.

## Interface
- NUM_SOURCES, 4: number of requesters (≥2)
- TDATA_WIDTH, 512: beat width
- TID_WIDTH, 2: tid width
- TDEST_WIDTH, 4: tdest width
- GW (local), $clog2(NUM_SOURCES): grant index width

Ports:
- clk  in  1  user clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- s_tvalid  in  1 [NUM_SOURCES]  per-source valid
- s_tready  out  1 [NUM_SOURCES]  per-source ready
- s_tdata  in  TDATA_WIDTH [NUM_SOURCES]  per-source data
- s_tlast  in  1 [NUM_SOURCES]  per-source end of packet
- s_tid  in  TID_WIDTH [NUM_SOURCES]  per-source tid
- s_tdest  in  TDEST_WIDTH [NUM_SOURCES]  per-source destination
- m_tvalid  out  1  to the endpoint's axis_in_tvalid
- m_tready  in  1  from the endpoint's axis_in_tready
- m_tdata / m_tlast / m_tid / m_tdest  out  TDATA_WIDTH / 1 / TID_WIDTH / TDEST_WIDTH  registered beat
- grant_id  out  GW  currently or last granted source
- busy  out  1  1 while in LOCKED

## Operation
The controller has two states, IDLE and LOCKED, plus a registered rr_ptr (GW bits).
- **IDLE:**
  - All s_tready are 0.
  - If any s_tvalid is 1, select the first requesting index k, searching rr_ptr, rr_ptr+1, … mod NUM_SOURCES.
  - Register grant_id=k and move to LOCKED.
  - If no source is valid, stay in IDLE.
- **LOCKED:**
  - s_tready[grant_id] = !m_tvalid || m_tready. Every other s_tready is 0.
  - A beat is accepted when s_tvalid[g] && s_tready[g]. The accepted data, tlast, tid and tdest are loaded into the output register and m_tvalid is set.
  - An accepted beat with s_tlast=1 returns the state to IDLE and sets rr_ptr = (g+1) mod NUM_SOURCES.
  - The grant holds even if s_tvalid[g] drops mid-packet, or drops before the first beat. There is no timeout.
- **Output register:**
  - Beat accepted: load the register and set m_tvalid=1.
  - Else if m_tready=1: clear m_tvalid.
  - Else: hold. m_* stay stable while m_tvalid && !m_tready.
- **Readiness path:** s_tready depends combinationally on m_tready; there is no skid buffer.
- **Fairness:** rr_ptr advances only on packet completion. A source that stops requesting is skipped at the next arbitration.
- **Wrap-around:** when NUM_SOURCES is not a power of two, rr_ptr wraps from NUM_SOURCES-1 to 0. The wrap never produces an index ≥ NUM_SOURCES.
- **Reset** (synchronous, in any state including mid-packet):
  - State goes to IDLE; rr_ptr=0, grant_id=0.
  - m_tvalid=0, all s_tready=0, busy=0.
  - m_tdata/m_tlast/m_tid/m_tdest are don't-care.
  - A truncated packet is not completed; the system resets the NoC together with the arbiter.

## Timing
- **Arbitration:** one cycle. If cycle t is in IDLE with a valid request, the grant is visible at t+1 and the first beat can be accepted at t+1.
- **First-beat latency:** a request raised in cycle t (IDLE, m_tready=1) gives m_tvalid=1 at t+2.
- **Throughput:** one beat per cycle inside a packet. There is one bubble cycle (IDLE) between packets, so an L-beat packet occupies L+1 cycles.
- **Tlast boundary:** the cycle after tlast acceptance is IDLE. At that cycle's edge the arbiter re-arbitrates with the updated rr_ptr.
- **busy:** equals (state==LOCKED), registered.

## Test plan
1. **Single source, 3-beat packet.** Reset, then source 0 presents a 3-beat packet from cycle 0 with m_tready=1. Required: grant_id=0 and busy=1 at cycle 1; m_tvalid=1 at cycles 2–4; m_tlast=1 at cycle 4; busy=0 at cycle 4.
2. **Round-robin order.** All 4 sources continuously offer 2-beat packets with m_tready=1. Required: the packet source order is 0,1,2,3,0,1. Each packet is 2 contiguous beats with matching tdest/tid, followed by 1 idle cycle.
3. **Backpressure.** m_tready=0 for 5 cycles while source 0 is mid-packet holding beat 0xA5. Required: m_tdata stays 0xA5 and m_tvalid stays 1; s_tready[0]=0; no beat is lost or duplicated after m_tready returns to 1.
4. **No interleaving.** Source 1 asserts valid during beat 2 of a 6-beat source-0 packet. Required: s_tready[1]=0 until after source 0's tlast; source 1's first beat appears at m_* exactly 2 cycles after source 0's tlast beat appears.
5. **Wrap with NUM_SOURCES=3.** Only source 2 requests, twice, with single-beat packets. Required: rr_ptr goes 2→0 after the first packet, source 2 is still granted next, and output is 1 beat every 2 cycles.
6. **Reset mid-packet.** rst=1 for 1 cycle during beat 3 of a 5-beat packet from source 3. Required: the cycle after reset, m_tvalid=0, all s_tready=0, busy=0 and grant_id=0; a new request from source 1 is then granted ahead of source 3 (rr_ptr=0).
